// File: rtl/data_bus_responder_if.sv
// Data-memory bus between the single-cycle core and its load/store responder.
// Latency: r_data is combinational from the request fields in the same cycle.
// Backpressure: none; the responder always services an access in one cycle.
// Ports: MemRead/MemWrite access strobes, addr byte address, w_data lane-aligned
//        store data, byte_enable write strobes, r_data raw load word.
interface data_bus_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] w_data;
  logic [3:0]  byte_enable;
  logic [31:0] r_data;

  modport master (
    output MemRead, MemWrite, addr, w_data, byte_enable,
    input  r_data
  );

  modport slave (
    input  MemRead, MemWrite, addr, w_data, byte_enable,
    output r_data
  );
endinterface

// File: rtl/data_bus_responder.sv
// Slave end of the core data-memory path: word RAM plus GPIO/timer/error registers.
// Latency: reads are combinational (zero cycles); writes commit at the next clk edge.
// Backpressure: none; every access completes in the cycle it is presented.
// Ports: clk, rst (sync, active-high), bus (slave modport of data_bus_responder_if),
//        gpio_in async inputs, gpio_out registered outputs, timer_irq level
//        interrupt mirroring the timer flag, bus_err sticky unmapped-access flag.
module data_bus_responder #(
  parameter int RAM_DEPTH = 1024,
  parameter int GPIO_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  data_bus_responder_if.slave   bus,
  input  logic [GPIO_W-1:0]     gpio_in,
  output logic [GPIO_W-1:0]     gpio_out,
  output logic                  timer_irq,
  output logic                  bus_err
);

  localparam int AW = $clog2(RAM_DEPTH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} timer_state_t;

  logic [31:0]       ram [RAM_DEPTH];
  logic [GPIO_W-1:0] gpio_s1, gpio_s2;
  logic [31:0]       timer_cnt, timer_cmp;
  logic              auto_reload, flag;
  timer_state_t      timer_state;

  // Word address; the byte offset never takes part in decode.
  logic [29:0] wa;
  assign wa = bus.addr[31:2];

  logic ram_hit, sel_gpo, sel_gpi, sel_cnt, sel_cmp, sel_ctrl, sel_err, mapped;
  assign ram_hit  = (bus.addr[31:AW+2] == '0);
  assign sel_gpo  = (wa == 30'h0400_0000);
  assign sel_gpi  = (wa == 30'h0400_0001);
  assign sel_cnt  = (wa == 30'h0400_0002);
  assign sel_cmp  = (wa == 30'h0400_0003);
  assign sel_ctrl = (wa == 30'h0400_0004);
  assign sel_err  = (wa == 30'h0400_0005);
  assign mapped   = ram_hit | sel_gpo | sel_gpi | sel_cnt | sel_cmp | sel_ctrl | sel_err;

  logic [AW-1:0] ram_idx;
  assign ram_idx = bus.addr[AW+1:2];

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return res;
  endfunction

  // Narrow registers are widened to a full word so reads and lane merges share one path.
  logic [31:0] gpio_out_ext, gpio_in_ext, gpio_merged;
  always_comb begin
    gpio_out_ext = '0;
    gpio_out_ext[GPIO_W-1:0] = gpio_out;
    gpio_in_ext = '0;
    gpio_in_ext[GPIO_W-1:0] = gpio_s2;
  end
  assign gpio_merged = merge_lanes(gpio_out_ext, bus.w_data, bus.byte_enable);

  logic unused_ok;
  assign unused_ok = ^{bus.addr[1:0], gpio_merged};

  logic wr_cnt, wr_cmp, wr_ctrl, wr_err, hw_match;
  assign wr_cnt   = bus.MemWrite & sel_cnt;
  assign wr_cmp   = bus.MemWrite & sel_cmp;
  assign wr_ctrl  = bus.MemWrite & sel_ctrl & bus.byte_enable[0];
  assign wr_err   = bus.MemWrite & sel_err & (|bus.byte_enable);
  assign hw_match = (timer_state == RUN) && (timer_cnt == timer_cmp);

  // Read mux; sequential state is read before this cycle's write lands.
  always_comb begin
    bus.r_data = '0;
    if (bus.MemRead) begin
      if (ram_hit)       bus.r_data = ram[ram_idx];
      else if (sel_gpo)  bus.r_data = gpio_out_ext;
      else if (sel_gpi)  bus.r_data = gpio_in_ext;
      else if (sel_cnt)  bus.r_data = timer_cnt;
      else if (sel_cmp)  bus.r_data = timer_cmp;
      else if (sel_ctrl) bus.r_data = {29'd0, flag, auto_reload, timer_state == RUN};
      else if (sel_err)  bus.r_data = {31'd0, bus_err};
    end
  end

  // RAM has no reset, but a store coinciding with reset is still dropped.
  always_ff @(posedge clk) begin
    if (!rst && bus.MemWrite && ram_hit) begin
      for (int i = 0; i < 4; i++)
        if (bus.byte_enable[i]) ram[ram_idx][8*i +: 8] <= bus.w_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_s1  <= '0;
      gpio_s2  <= '0;
      gpio_out <= '0;
      bus_err  <= 1'b0;
    end else begin
      gpio_s1 <= gpio_in;
      gpio_s2 <= gpio_s1;
      if (bus.MemWrite && sel_gpo) gpio_out <= gpio_merged[GPIO_W-1:0];
      if ((bus.MemRead || bus.MemWrite) && !mapped) bus_err <= 1'b1;
      else if (wr_err)                              bus_err <= 1'b0;
    end
  end

  // Timer FSM: hardware update first, bus writes afterwards so they take precedence,
  // except that a match setting the flag wins over a same-cycle write-1-to-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_state <= IDLE;
      timer_cnt   <= '0;
      timer_cmp   <= '1;
      auto_reload <= 1'b0;
      flag        <= 1'b0;
    end else begin
      if (timer_state == RUN) begin
        if (hw_match) begin
          flag <= 1'b1;
          if (auto_reload) timer_cnt   <= '0;
          else             timer_state <= IDLE;
        end else begin
          timer_cnt <= timer_cnt + 32'd1;
        end
      end
      if (wr_cnt) timer_cnt <= merge_lanes(timer_cnt, bus.w_data, bus.byte_enable);
      if (wr_cmp) timer_cmp <= merge_lanes(timer_cmp, bus.w_data, bus.byte_enable);
      if (wr_ctrl) begin
        timer_state <= bus.w_data[0] ? RUN : IDLE;
        auto_reload <= bus.w_data[1];
        if (bus.w_data[2] && !hw_match) flag <= 1'b0;
      end
    end
  end

  assign timer_irq = flag;

endmodule

// File: tb/tb_data_bus_responder.sv
module tb_data_bus_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] gpio_in = '0;
  logic [15:0] gpio_out;
  logic        timer_irq, bus_err;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] rv;

  localparam logic [31:0] A_GPO  = 32'h1000_0000;
  localparam logic [31:0] A_GPI  = 32'h1000_0004;
  localparam logic [31:0] A_CNT  = 32'h1000_0008;
  localparam logic [31:0] A_CMP  = 32'h1000_000C;
  localparam logic [31:0] A_CTRL = 32'h1000_0010;
  localparam logic [31:0] A_ERR  = 32'h1000_0014;

  data_bus_responder_if bus_if();

  data_bus_responder #(.RAM_DEPTH(1024), .GPIO_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus_if), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .timer_irq(timer_irq), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Presents a store, lets it commit at the next edge, then samples 1ns later.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus_if.addr = a; bus_if.w_data = d; bus_if.byte_enable = be;
    bus_if.MemWrite = 1'b1; bus_if.MemRead = 1'b0;
    @(posedge clk); #1;
    bus_if.MemWrite = 1'b0; bus_if.byte_enable = 4'h0;
  endtask

  // Combinational load between edges; no clock edge occurs while MemRead is high.
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus_if.addr = a; bus_if.MemRead = 1'b1; bus_if.MemWrite = 1'b0;
    #1 d = bus_if.r_data;
    bus_if.MemRead = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (gpio_out !== 16'h0) begin n_fail++; $display("FAIL reset_gpio_out got %h want 0000", gpio_out); end
    n_cmp++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", timer_irq); end
    n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err got %b want 0", bus_err); end
    rst = 1'b0;
    rd(A_CMP, rv);
    n_cmp++; if (rv !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_cmp got %h want ffffffff", rv); end
    rd(A_CNT, rv);
    n_cmp++; if (rv !== 32'h0) begin n_fail++; $display("FAIL reset_cnt got %h want 00000000", rv); end
    rd(A_CTRL, rv);
    n_cmp++; if (rv !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl got %h want 00000000", rv); end
  endtask

  task automatic test_ram();
    wr(32'h40, 32'hAABB_CCDD, 4'b1111);
    wr(32'h40, 32'h0000_0011, 4'b0001);
    rd(32'h40, rv);
    n_cmp++; if (rv !== 32'hAABB_CC11) begin n_fail++; $display("FAIL ram_lane got %h want aabbcc11", rv); end
    wr(32'h43, 32'hFFFF_FFFF, 4'b0000);
    rd(32'h40, rv);
    n_cmp++; if (rv !== 32'hAABB_CC11) begin n_fail++; $display("FAIL ram_be0 got %h want aabbcc11", rv); end
    wr(32'h44, 32'h1234_5678, 4'b1100);
    wr(32'h44, 32'h0000_9ABC, 4'b0011);
    rd(32'h46, rv);
    n_cmp++; if (rv !== 32'h1234_9ABC) begin n_fail++; $display("FAIL ram_offset got %h want 12349abc", rv); end
    // Simultaneous load and store: load sees the old word.
    bus_if.addr = 32'h40; bus_if.w_data = 32'h5566_7788; bus_if.byte_enable = 4'hF;
    bus_if.MemRead = 1'b1; bus_if.MemWrite = 1'b1;
    #1;
    n_cmp++; if (bus_if.r_data !== 32'hAABB_CC11) begin n_fail++; $display("FAIL ram_rw_old got %h want aabbcc11", bus_if.r_data); end
    @(posedge clk); #1;
    bus_if.MemRead = 1'b0; bus_if.MemWrite = 1'b0;
    rd(32'h40, rv);
    n_cmp++; if (rv !== 32'h5566_7788) begin n_fail++; $display("FAIL ram_rw_new got %h want 55667788", rv); end
    #1;
    n_cmp++; if (bus_if.r_data !== 32'h0) begin n_fail++; $display("FAIL rdata_idle got %h want 0", bus_if.r_data); end
  endtask

  task automatic test_timer_reload();
    wr(A_CMP, 32'd5, 4'hF);
    wr(A_CTRL, 32'h3, 4'h1);
    rd(A_CNT, rv);
    n_cmp++; if (rv !== 32'd0) begin n_fail++; $display("FAIL tmr_start got %0d want 0", rv); end
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      rd(A_CNT, rv);
      n_cmp++; if (rv !== 32'(k) || timer_irq !== 1'b0) begin
        n_fail++; $display("FAIL tmr_count got cnt=%0d irq=%b want cnt=%0d irq=0", rv, timer_irq, k);
      end
    end
    @(posedge clk); #1;
    rd(A_CNT, rv);
    n_cmp++; if (timer_irq !== 1'b1 || rv !== 32'd0) begin
      n_fail++; $display("FAIL tmr_match got irq=%b cnt=%0d want irq=1 cnt=0", timer_irq, rv);
    end
    // cnt is 0 now, so this W1C cannot coincide with a match.
    wr(A_CTRL, 32'h7, 4'h1);
    rd(A_CTRL, rv);
    n_cmp++; if (rv !== 32'h3 || timer_irq !== 1'b0) begin
      n_fail++; $display("FAIL tmr_w1c got ctrl=%h irq=%b want ctrl=3 irq=0", rv, timer_irq);
    end
    repeat (4) @(posedge clk);
    #1;
    rd(A_CNT, rv);
    n_cmp++; if (rv !== 32'd5) begin n_fail++; $display("FAIL tmr_prematch got %0d want 5", rv); end
    wr(A_CTRL, 32'h7, 4'h1);
    rd(A_CNT, rv);
    n_cmp++; if (timer_irq !== 1'b1 || rv !== 32'd0) begin
      n_fail++; $display("FAIL tmr_set_beats_w1c got irq=%b cnt=%0d want irq=1 cnt=0", timer_irq, rv);
    end
    // CNT write overrides the increment in the same cycle.
    wr(A_CNT, 32'd2, 4'hF);
    rd(A_CNT, rv);
    n_cmp++; if (rv !== 32'd2) begin n_fail++; $display("FAIL tmr_cnt_wr got %0d want 2", rv); end
    wr(A_CTRL, 32'h4, 4'h1);
    wr(A_CNT, 32'd0, 4'hF);
  endtask

  task automatic test_timer_oneshot();
    wr(A_CMP, 32'd3, 4'hF);
    wr(A_CTRL, 32'h1, 4'h1);
    repeat (4) @(posedge clk);
    #1;
    rd(A_CTRL, rv);
    n_cmp++; if (rv !== 32'h4 || timer_irq !== 1'b1) begin
      n_fail++; $display("FAIL oneshot_ctrl got ctrl=%h irq=%b want ctrl=4 irq=1", rv, timer_irq);
    end
    repeat (3) @(posedge clk);
    #1;
    rd(A_CNT, rv);
    n_cmp++; if (rv !== 32'd3) begin n_fail++; $display("FAIL oneshot_hold got %0d want 3", rv); end
    wr(A_CTRL, 32'h4, 4'h1);
    n_cmp++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_clear got %b want 0", timer_irq); end
  endtask

  task automatic test_gpio();
    gpio_in = 16'h00A5;
    @(posedge clk); #1;
    rd(A_GPI, rv);
    n_cmp++; if (rv !== 32'h0) begin n_fail++; $display("FAIL gpi_1cyc got %h want 0", rv); end
    @(posedge clk); #1;
    rd(A_GPI, rv);
    n_cmp++; if (rv !== 32'h0000_00A5) begin n_fail++; $display("FAIL gpi_2cyc got %h want 000000a5", rv); end
    wr(A_GPO, 32'h0000_1234, 4'b0011);
    n_cmp++; if (gpio_out !== 16'h1234) begin n_fail++; $display("FAIL gpo_write got %h want 1234", gpio_out); end
    wr(A_GPO, 32'hFFFF_5678, 4'b0001);
    rd(A_GPO, rv);
    n_cmp++; if (rv !== 32'h0000_1278 || gpio_out !== 16'h1278) begin
      n_fail++; $display("FAIL gpo_lane got rd=%h pin=%h want 00001278", rv, gpio_out);
    end
    wr(A_GPI, 32'hFFFF_FFFF, 4'hF);
    rd(A_GPI, rv);
    n_cmp++; if (rv !== 32'h0000_00A5 || bus_err !== 1'b0) begin
      n_fail++; $display("FAIL gpi_ro got %h err=%b want 000000a5 err=0", rv, bus_err);
    end
  endtask

  task automatic test_bus_err();
    bus_if.addr = 32'h2000_0000; bus_if.MemRead = 1'b1;
    #1;
    n_cmp++; if (bus_if.r_data !== 32'h0 || bus_err !== 1'b0) begin
      n_fail++; $display("FAIL err_rdata got %h err=%b want 0 err=0", bus_if.r_data, bus_err);
    end
    @(posedge clk); #1;
    bus_if.MemRead = 1'b0;
    n_cmp++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", bus_err); end
    repeat (3) @(posedge clk);
    #1;
    rd(A_ERR, rv);
    n_cmp++; if (rv !== 32'h1 || bus_err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky got reg=%h pin=%b want 1", rv, bus_err);
    end
    wr(A_ERR, 32'h0, 4'hF);
    n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b want 0", bus_err); end
    wr(32'h0000_1000, 32'h1, 4'hF);
    n_cmp++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL err_ram_edge got %b want 1", bus_err); end
    wr(A_ERR, 32'h0, 4'hF);
  endtask

  task automatic test_reset_mid();
    wr(A_CMP, 32'd9, 4'hF);
    bus_if.addr = A_GPO; bus_if.w_data = 32'h0000_BEEF; bus_if.byte_enable = 4'hF;
    bus_if.MemWrite = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    bus_if.MemWrite = 1'b0; rst = 1'b0;
    n_cmp++; if (gpio_out !== 16'h0) begin n_fail++; $display("FAIL midrst_gpo got %h want 0000", gpio_out); end
    rd(A_CMP, rv);
    n_cmp++; if (rv !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL midrst_cmp got %h want ffffffff", rv); end
  endtask

  initial begin
    bus_if.MemRead = 1'b0; bus_if.MemWrite = 1'b0; bus_if.addr = '0;
    bus_if.w_data = '0; bus_if.byte_enable = '0;
    @(negedge clk);
    test_reset();
    test_ram();
    test_timer_reload();
    test_timer_oneshot();
    test_gpio();
    test_bus_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
